mem_arbiter: RTL and testbench

Main-memory arbiter and transfer sequencer sharing the single `MainMemory_Multiword` port between the instruction-cache refill path and the data-memory path.
- Accepts line-read requests from the I-cache controller and line-read or word-write requests from the MEM stage.
- Grants one requester at a time with round-robin tie-break and runs a fixed-latency transfer.
- Returns the 64-bit line with a one-cycle done pulse and keeps per-requester transaction counts.

---
 rtl/mem_arb_pkg.sv | 27 ++
 rtl/mem_arbiter_if.sv | 35 +++
 rtl/xfer_timer.sv | 19 +
 rtl/mem_arbiter.sv | 90 +++++++++
 tb/tb_mem_arbiter.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the main-memory arbiter: state encoding,
// bus widths, owner codes and the registered transfer descriptor.
package mem_arb_pkg;
  localparam int LINE_W = 64;
  localparam int WORD_W = 32;

  localparam logic OWNER_I = 1'b0;
  localparam logic OWNER_D = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    I_XFER = 2'b01,
    D_XFER = 2'b10,
    DONE   = 2'b11
  } arb_state_e;

  typedef struct packed {
    logic              wr;
    logic [WORD_W-1:0] addr;
    logic [WORD_W-1:0] wdata;
  } xfer_req_t;

  // Line reads drop the byte-in-line bits, word writes the byte-in-word bits.
  function automatic logic [WORD_W-1:0] align_addr(logic [WORD_W-1:0] a, logic wr);
    return wr ? {a[WORD_W-1:2], 2'b00} : {a[WORD_W-1:3], 3'b000};
  endfunction
endpackage

// File: rtl/mem_arbiter_if.sv
// Requester, memory and status signals of the arbiter bundled together;
// slave = the arbiter, master = requesters plus memory.
interface mem_arbiter_if import mem_arb_pkg::*; #(parameter int CNT_W = 20);
  logic              I_Req;
  logic [WORD_W-1:0] I_Addr;
  logic              I_Done;
  logic [LINE_W-1:0] I_Data;
  logic              D_Req;
  logic              D_Write;
  logic [WORD_W-1:0] D_Addr;
  logic [WORD_W-1:0] D_WData;
  logic              D_Done;
  logic [LINE_W-1:0] D_Data;
  logic              MM_Access;
  logic              MM_Write;
  logic [WORD_W-1:0] MM_Addr;
  logic [WORD_W-1:0] MM_WData;
  logic [LINE_W-1:0] MM_Data;
  logic              Busy;
  logic              Grant_D;
  logic [CNT_W-1:0]  CNT_I;
  logic [CNT_W-1:0]  CNT_D;

  modport slave (
    input  I_Req, I_Addr, D_Req, D_Write, D_Addr, D_WData, MM_Data,
    output I_Done, I_Data, D_Done, D_Data, MM_Access, MM_Write, MM_Addr,
           MM_WData, Busy, Grant_D, CNT_I, CNT_D
  );

  modport master (
    output I_Req, I_Addr, D_Req, D_Write, D_Addr, D_WData, MM_Data,
    input  I_Done, I_Data, D_Done, D_Data, MM_Access, MM_Write, MM_Addr,
           MM_WData, Busy, Grant_D, CNT_I, CNT_D
  );
endinterface

// File: rtl/xfer_timer.sv
// 4-bit loadable down-counter timing one memory transfer; holds at zero.
module xfer_timer (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       load,
  input  logic       en,
  input  logic [3:0] load_val,
  output logic       zero
);
  logic [3:0] cnt_q;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET)                   cnt_q <= '0;
    else if (load)                cnt_q <= load_val;
    else if (en && cnt_q != 4'd0) cnt_q <= cnt_q - 4'd1;
  end

  assign zero = (cnt_q == 4'd0);
endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter between I-cache refills and MEM-stage accesses onto
// one fixed-latency main-memory port, with saturating per-owner counters.
module mem_arbiter import mem_arb_pkg::*; #(
  parameter int MM_LATENCY = 4,
  parameter int CNT_W      = 20
) (
  input  logic          CLK,
  input  logic          RESET,
  mem_arbiter_if.slave  bus
);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  arb_state_e        state_q, state_d;
  logic              last_d_q;
  xfer_req_t         req_q;
  logic [LINE_W-1:0] i_data_q, d_data_q;
  logic [CNT_W-1:0]  cnt_i_q, cnt_d_q;
  logic              grant, grant_d_sel, t_zero, mm_access;

  assign mm_access = (state_q == I_XFER) || (state_q == D_XFER);

  xfer_timer u_timer (
    .CLK      (CLK),
    .RESET    (RESET),
    .load     (grant),
    .en       (mm_access),
    .load_val (4'(MM_LATENCY - 1)),
    .zero     (t_zero)
  );

  always_comb begin
    state_d     = state_q;
    grant       = 1'b0;
    grant_d_sel = last_d_q;
    case (state_q)
      IDLE: if (bus.I_Req || bus.D_Req) begin
        grant       = 1'b1;
        grant_d_sel = (bus.I_Req && bus.D_Req) ? ~last_d_q : bus.D_Req;
        state_d     = grant_d_sel ? D_XFER : I_XFER;
      end
      I_XFER, D_XFER: if (t_zero) state_d = DONE;
      DONE:           state_d = IDLE;
      default:        state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q  <= IDLE;
      last_d_q <= OWNER_I;
      req_q    <= '0;
      i_data_q <= '0;
      d_data_q <= '0;
      cnt_i_q  <= '0;
      cnt_d_q  <= '0;
    end else begin
      state_q <= state_d;
      if (grant) begin
        last_d_q <= grant_d_sel;
        req_q.wr <= grant_d_sel & bus.D_Write;
        req_q.addr <= grant_d_sel ? align_addr(bus.D_Addr, bus.D_Write)
                                  : align_addr(bus.I_Addr, 1'b0);
        if (grant_d_sel) req_q.wdata <= bus.D_WData;
      end
      // Capture lands in the last access cycle so the line is ready with Done.
      if (state_q == I_XFER && t_zero)              i_data_q <= bus.MM_Data;
      if (state_q == D_XFER && t_zero && !req_q.wr) d_data_q <= bus.MM_Data;
      if (state_q == DONE) begin
        if (last_d_q == OWNER_D) begin
          if (~&cnt_d_q) cnt_d_q <= cnt_d_q + CNT_ONE;
        end else begin
          if (~&cnt_i_q) cnt_i_q <= cnt_i_q + CNT_ONE;
        end
      end
    end
  end

  assign bus.MM_Access = mm_access;
  assign bus.MM_Write  = (state_q == D_XFER) && req_q.wr;
  assign bus.MM_Addr   = req_q.addr;
  assign bus.MM_WData  = req_q.wdata;
  assign bus.Busy      = (state_q != IDLE);
  assign bus.Grant_D   = last_d_q;
  assign bus.I_Done    = (state_q == DONE) && (last_d_q == OWNER_I);
  assign bus.D_Done    = (state_q == DONE) && (last_d_q == OWNER_D);
  assign bus.I_Data    = i_data_q;
  assign bus.D_Data    = d_data_q;
  assign bus.CNT_I     = cnt_i_q;
  assign bus.CNT_D     = cnt_d_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios followed by random request traffic,
// all checked every cycle against a transaction-phase reference model.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int L   = 4;
  localparam int CW  = 2;
  localparam int SAT = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_arbiter_if #(.CNT_W(CW)) bus();
  mem_arbiter #(.MM_LATENCY(L), .CNT_W(CW)) u_dut (.CLK(clk), .RESET(rst_n), .bus(bus));

  int total = 0;
  int bad   = 0;

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      if (bad <= 40) $display("FAIL %s: got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: ph = 0 idle, 1..L memory access cycles, L+1 done cycle.
  int          ph, m_ci, m_cd, cyc, i_dn, d_dn, i_done_cyc;
  bit          last_d, m_wr;
  logic [31:0] m_addr, m_wdata;
  logic [63:0] m_idata, m_ddata;

  function automatic void model_reset();
    ph = 0; last_d = 1'b0; m_wr = 1'b0; m_addr = '0; m_wdata = '0;
    m_idata = '0; m_ddata = '0; m_ci = 0; m_cd = 0;
  endfunction

  function automatic void model_next();
    if (!rst_n) begin
      model_reset();
    end else if (ph == 0) begin
      if (bus.I_Req || bus.D_Req) begin
        last_d = (bus.I_Req && bus.D_Req) ? !last_d : bus.D_Req;
        m_wr   = last_d && bus.D_Write;
        if (last_d) begin
          m_addr  = bus.D_Addr & (bus.D_Write ? ~32'h3 : ~32'h7);
          m_wdata = bus.D_WData;
        end else begin
          m_addr = bus.I_Addr & ~32'h7;
        end
        ph = 1;
      end
    end else if (ph <= L) begin
      if (ph == L) begin
        if (!last_d) m_idata = bus.MM_Data;
        else if (!m_wr) m_ddata = bus.MM_Data;
      end
      ph++;
    end else begin
      if (last_d) m_cd = (m_cd == SAT) ? SAT : m_cd + 1;
      else        m_ci = (m_ci == SAT) ? SAT : m_ci + 1;
      ph = 0;
    end
  endfunction

  task automatic check_all();
    bit acc;
    acc = (ph >= 1) && (ph <= L);
    chk("busy",      64'(bus.Busy),      64'(ph != 0));
    chk("mm_access", 64'(bus.MM_Access), 64'(acc));
    chk("mm_write",  64'(bus.MM_Write),  64'(acc && last_d && m_wr));
    if (acc) chk("mm_addr", 64'(bus.MM_Addr), 64'(m_addr));
    if (acc && last_d && m_wr) chk("mm_wdata", 64'(bus.MM_WData), 64'(m_wdata));
    chk("grant_d",   64'(bus.Grant_D),   64'(last_d));
    chk("i_done",    64'(bus.I_Done),    64'(ph == L + 1 && !last_d));
    chk("d_done",    64'(bus.D_Done),    64'(ph == L + 1 && last_d));
    chk("i_data",    bus.I_Data,         m_idata);
    chk("d_data",    bus.D_Data,         m_ddata);
    chk("cnt_i",     64'(bus.CNT_I),     64'(m_ci));
    chk("cnt_d",     64'(bus.CNT_D),     64'(m_cd));
  endtask

  task automatic tick();
    model_next();
    @(posedge clk); #1;
    cyc++;
    check_all();
    if (bus.I_Done) begin bus.I_Req = 1'b0; i_dn++; i_done_cyc = cyc; end
    if (bus.D_Done) begin bus.D_Req = 1'b0; d_dn++; end
    bus.MM_Data = {$urandom, $urandom};
  endtask

  task automatic wait_done(string tag, bit want_i, bit want_d);
    int si, sd, n;
    si = i_dn; sd = d_dn; n = 0;
    while (((want_i && i_dn == si) || (want_d && d_dn == sd)) && n < 40) begin
      tick(); n++;
    end
    chk(tag, 64'(n < 40), 64'd1);
  endtask

  initial begin
    logic [63:0] d_before;
    int          n_before;
    bus.I_Req = 0; bus.I_Addr = 0; bus.D_Req = 0; bus.D_Write = 0;
    bus.D_Addr = 0; bus.D_WData = 0; bus.MM_Data = 64'h0123_4567_89ab_cdef;
    cyc = 0; i_dn = 0; d_dn = 0; i_done_cyc = 0;
    model_reset();
    #1 check_all();
    tick(); tick();
    rst_n = 1'b1;

    // Uncontended I read: access cycles 1..4, done at cycle 5.
    bus.I_Req = 1; bus.I_Addr = 32'h0000_0014; cyc = 0;
    wait_done("i_first_to", 1, 0);
    chk("i_latency", 64'(i_done_cyc), 64'd5);
    tick();
    chk("i_cnt_one", 64'(bus.CNT_I), 64'd1);

    // Ties: first after an I grant goes to D, then the waiting I.
    bus.I_Req = 1; bus.D_Req = 1; bus.I_Addr = $urandom; bus.D_Addr = $urandom;
    tick();
    chk("tie1_grant", 64'(bus.Grant_D), 64'd1);
    wait_done("tie1_to", 1, 1);
    tick();
    bus.D_Req = 1; bus.D_Write = 0; bus.D_Addr = $urandom;
    wait_done("dread_to", 0, 1);
    tick();
    bus.I_Req = 1; bus.D_Req = 1;
    tick();
    chk("tie2_grant", 64'(bus.Grant_D), 64'd0);
    wait_done("tie2_to", 1, 1);
    tick();

    // Word write leaves D_Data alone.
    d_before = bus.D_Data;
    bus.D_Req = 1; bus.D_Write = 1; bus.D_Addr = 32'h100; bus.D_WData = 32'hDEADBEEF;
    tick();
    chk("wr_mm_wdata", 64'(bus.MM_WData), 64'hDEADBEEF);
    chk("wr_mm_addr",  64'(bus.MM_Addr),  64'h100);
    bus.D_WData = 32'h1234_5678;
    wait_done("wr_to", 0, 1);
    chk("wr_ddata_hold", bus.D_Data, d_before);

    // D read dropped mid-transfer still completes.
    tick();
    bus.D_Req = 1; bus.D_Write = 0; bus.D_Addr = 32'h0000_2468;
    tick(); tick();
    bus.D_Req = 0;
    wait_done("drop_to", 0, 1);
    tick();
    chk("drop_idle", 64'(bus.Busy), 64'd0);

    // Async reset in cycle 2 of an I transfer.
    bus.I_Req = 1; bus.I_Addr = $urandom;
    tick(); tick();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_access",  64'(bus.MM_Access), 64'd0);
    chk("rst_busy",    64'(bus.Busy),      64'd0);
    chk("rst_mm_addr", 64'(bus.MM_Addr),   64'd0);
    chk("rst_idata",   bus.I_Data,         64'd0);
    chk("rst_cnt",     64'({bus.CNT_I, bus.CNT_D}), 64'd0);
    model_reset();
    tick();
    rst_n = 1'b1;
    n_before = i_dn;
    wait_done("rst_xfer_to", 1, 0);
    repeat (L + 3) tick();
    chk("rst_one_done", 64'(i_dn - n_before), 64'd1);

    // Five more I reads saturate the 2-bit counter at 3.
    for (int k = 0; k < 5; k++) begin
      bus.I_Req = 1; bus.I_Addr = $urandom;
      wait_done("sat_to", 1, 0);
      tick();
    end
    chk("cnt_sat", 64'(bus.CNT_I), 64'd3);

    // Random traffic, including early drops and input churn after grant.
    for (int k = 0; k < 3000; k++) begin
      tick();
      if (!bus.I_Req && $urandom_range(2) == 0) bus.I_Req = 1;
      else if (bus.I_Req && $urandom_range(29) == 0) bus.I_Req = 0;
      if (!bus.D_Req && $urandom_range(2) == 0) bus.D_Req = 1;
      else if (bus.D_Req && $urandom_range(29) == 0) bus.D_Req = 0;
      bus.I_Addr  = $urandom;
      bus.D_Addr  = $urandom;
      bus.D_WData = $urandom;
      bus.D_Write = 1'($urandom_range(1));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
